regs_param: RTL and testbench

REGS_PARAM -- requirements
Module: regs_param

---
 rtl/regs_param.sv | 122 ++++++++++++
 tb/tb_regs_param.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/regs_param.sv
// Three-read / one-write register file with byte enables and a sequential clear FSM.
// Defining REGS_BYPASS_EN forwards an accepted write to matching read ports in the same cycle.
module regs_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  L_S,
    input  logic [ADDR_W-1:0]     Wt_addr,
    input  logic [DATA_W-1:0]     Wt_data,
    input  logic [DATA_W/8-1:0]   Wt_be,
    input  logic [ADDR_W-1:0]     R_addr_A,
    input  logic [ADDR_W-1:0]     R_addr_B,
    input  logic [ADDR_W-1:0]     R_addr_C,
    output logic [DATA_W-1:0]     rdata_A,
    output logic [DATA_W-1:0]     rdata_B,
    output logic [DATA_W-1:0]     rdata_C,
    input  logic                  clr_req,
    output logic                  clr_busy,
    output logic                  wr_drop
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   clr_cnt_q;
    logic                clr_busy_q;
    logic                wr_drop_q;
    logic                wr_drop_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                wr_try;
    logic                wr_acc;
    logic [DATA_W-1:0]   wr_word_d;

    function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                      input logic [DATA_W-1:0] new_w,
                                                      input logic [NB-1:0]     be);
        logic [DATA_W-1:0] r;
        r = old_w;
        for (int k = 0; k < NB; k++) begin
            if (be[k]) r[8*k +: 8] = new_w[8*k +: 8];
        end
        return r;
    endfunction

    function automatic logic is_zero_addr(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Writes to the hardwired zero entry or with no enabled bytes are no-ops, never drops.
    always_comb begin
        wr_try    = rst && L_S && (Wt_be != '0) && !is_zero_addr(Wt_addr);
        wr_acc    = wr_try && (state_q == IDLE) && !clr_req;
        wr_drop_d = wr_try && ((state_q == CLEAR) || clr_req);
        wr_word_d = merge_bytes(mem_q[Wt_addr], Wt_data, Wt_be);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (state_q == CLEAR) begin
            mem_q[clr_cnt_q] <= '0;
        end else if (wr_acc) begin
            mem_q[Wt_addr] <= wr_word_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            clr_cnt_q  <= '0;
            clr_busy_q <= 1'b0;
            wr_drop_q  <= 1'b0;
        end else begin
            wr_drop_q <= wr_drop_d;
            case (state_q)
                IDLE: begin
                    if (clr_req) begin
                        state_q    <= CLEAR;
                        clr_cnt_q  <= '0;
                        clr_busy_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    if (clr_cnt_q == '1) begin
                        state_q    <= IDLE;
                        clr_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    clr_busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Zero-entry masking is applied last so it wins over the bypass path.
    always_comb begin
        rdata_A = mem_q[R_addr_A];
        rdata_B = mem_q[R_addr_B];
        rdata_C = mem_q[R_addr_C];
`ifdef REGS_BYPASS_EN
        if (wr_acc && (R_addr_A == Wt_addr)) rdata_A = wr_word_d;
        if (wr_acc && (R_addr_B == Wt_addr)) rdata_B = wr_word_d;
        if (wr_acc && (R_addr_C == Wt_addr)) rdata_C = wr_word_d;
`endif
        if (is_zero_addr(R_addr_A)) rdata_A = '0;
        if (is_zero_addr(R_addr_B)) rdata_B = '0;
        if (is_zero_addr(R_addr_C)) rdata_C = '0;
    end

    assign clr_busy = clr_busy_q;
    assign wr_drop  = wr_drop_q;

endmodule

// File: tb/tb_regs_param.sv
// Scoreboard bench for regs_param: stimulus queues expected outputs, a negedge monitor compares.
// Honors REGS_BYPASS_EN for the same-cycle read-after-write expectation.
module tb_regs_param;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NB = 4;
    localparam int DEPTH = 32;
    localparam logic [4:0] M_A = 5'd1, M_B = 5'd2, M_C = 5'd4, M_BSY = 5'd8, M_DRP = 5'd16;
    localparam logic [4:0] M_RD = 5'd7, M_ALL = 5'd31;
`ifdef REGS_BYPASS_EN
    localparam logic [DW-1:0] BYP_C = 32'hDEADBEEF;
`else
    localparam logic [DW-1:0] BYP_C = 32'hA5A5A5A5;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, L_S, clr_req, clr_busy, wr_drop;
    logic [AW-1:0] Wt_addr, R_addr_A, R_addr_B, R_addr_C;
    logic [DW-1:0] Wt_data, rdata_A, rdata_B, rdata_C;
    logic [NB-1:0] Wt_be;

    regs_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .L_S(L_S), .Wt_addr(Wt_addr), .Wt_data(Wt_data), .Wt_be(Wt_be),
        .R_addr_A(R_addr_A), .R_addr_B(R_addr_B), .R_addr_C(R_addr_C),
        .rdata_A(rdata_A), .rdata_B(rdata_B), .rdata_C(rdata_C),
        .clr_req(clr_req), .clr_busy(clr_busy), .wr_drop(wr_drop)
    );

    typedef struct {
        string         name;
        logic [DW-1:0] a, b, c;
        logic          busy, drop;
        logic [4:0]    m;
    } exp_t;

    exp_t          sb[$];
    logic          chk_vld = 1'b0;
    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] model [DEPTH];

    task automatic check_f(input string n, input string f, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s got %h expected %h", n, f, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (chk_vld) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL scoreboard got empty queue expected an entry");
            end else begin
                e = sb.pop_front();
                if (e.m[0]) check_f(e.name, "rdata_A", rdata_A, e.a);
                if (e.m[1]) check_f(e.name, "rdata_B", rdata_B, e.b);
                if (e.m[2]) check_f(e.name, "rdata_C", rdata_C, e.c);
                if (e.m[3]) check_f(e.name, "clr_busy", {{(DW-1){1'b0}}, clr_busy}, {{(DW-1){1'b0}}, e.busy});
                if (e.m[4]) check_f(e.name, "wr_drop", {{(DW-1){1'b0}}, wr_drop}, {{(DW-1){1'b0}}, e.drop});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        chk_vld = 1'b0;
        L_S     = 1'b0;
        clr_req = 1'b0;
        Wt_be   = '0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
        L_S = 1'b1; Wt_addr = a; Wt_data = d; Wt_be = be;
    endtask

    task automatic expect_rd(input string n, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                             input logic [AW-1:0] rc, input logic [DW-1:0] ea, input logic [DW-1:0] eb,
                             input logic [DW-1:0] ec, input logic ebsy, input logic edrp, input logic [4:0] m);
        exp_t e;
        R_addr_A = ra; R_addr_B = rb; R_addr_C = rc;
        e.name = n; e.a = ea; e.b = eb; e.c = ec; e.busy = ebsy; e.drop = edrp; e.m = m;
        sb.push_back(e);
        chk_vld = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] p;
        rst = 1'b0; L_S = 1'b0; clr_req = 1'b0; Wt_addr = '0; Wt_data = '0; Wt_be = '0;
        R_addr_A = '0; R_addr_B = '0; R_addr_C = '0;
        repeat (2) @(posedge clk);
        #1;
        wr(5, 32'hFFFFFFFF, 4'hf);
        expect_rd("in_reset", 5, 1, 31, 0, 0, 0, 1'b0, 1'b0, M_ALL);
        tick();
        rst = 1'b1;
        expect_rd("post_reset", 5, 1, 31, 0, 0, 0, 1'b0, 1'b0, M_ALL);
        tick();

        p = 32'h5a5a5a5a;
        for (int i = 0; i < DEPTH; i++) begin
            wr(AW'(i), p, 4'hf);
            model[i] = (i == 0) ? '0 : p;
            tick();
            p = ~p;
        end
        for (int i = 0; i < DEPTH; i++) begin
            expect_rd($sformatf("fill%0d", i), AW'(i), AW'(31 - i), AW'(i),
                      model[i], model[31 - i], model[i], 1'b0, 1'b0, M_ALL);
            tick();
        end

        wr(3, 32'h11223344, 4'hf); tick();
        wr(3, 32'hAABBCCDD, 4'b0101); tick();
        wr(3, 32'hFFFFFFFF, 4'h0);
        expect_rd("be_zero", 3, 3, 3, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD, 1'b0, 1'b0, M_RD | M_DRP);
        tick();
        expect_rd("be_merge", 3, 0, 3, 32'h11BB33DD, 0, 32'h11BB33DD, 1'b0, 1'b0, M_RD | M_DRP);
        tick();
        wr(0, 32'h12345678, 4'hf);
        expect_rd("zero_wr_same", 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, M_RD);
        tick();
        expect_rd("zero_wr_after", 0, 3, 0, 0, 32'h11BB33DD, 0, 1'b0, 1'b0, M_RD | M_DRP);
        tick();

        wr(7, 32'hDEADBEEF, 4'hf);
        expect_rd("byp_same", 6, 8, 7, 32'h5a5a5a5a, 32'h5a5a5a5a, BYP_C, 1'b0, 1'b0, M_RD);
        tick();
        expect_rd("byp_next", 7, 7, 7, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, M_RD);
        tick();

        // Clear sequence with a write on the start edge, a write mid-clear and a repeated request.
        for (int i = 1; i < DEPTH; i++) begin
            wr(AW'(i), 32'(i), 4'hf);
            tick();
        end
        clr_req = 1'b1;
        wr(20, 32'hFFFFFFFF, 4'hf);
        expect_rd("clr_start", 20, 0, 0, 32'd20, 0, 0, 1'b0, 1'b0, M_A | M_BSY | M_DRP);
        tick();
        for (int k = 0; k < DEPTH; k++) begin
            if (k == 2) wr(9, 32'h99999999, 4'hf);
            if (k == 5) clr_req = 1'b1;
            expect_rd($sformatf("clr%0d", k), (k == 0) ? AW'(0) : AW'(k - 1), AW'(k), 31,
                      0, 32'(k), 32'd31, 1'b1, (k == 0 || k == 3), M_ALL);
            tick();
        end
        expect_rd("clr_done", 31, 20, 9, 0, 0, 0, 1'b0, 1'b0, M_ALL);
        tick();
        for (int j = 0; j < 11; j++) begin
            expect_rd($sformatf("clr_all%0d", j), AW'(3 * j), AW'((3 * j + 1) % 32), AW'((3 * j + 2) % 32),
                      0, 0, 0, 1'b0, 1'b0, M_ALL);
            tick();
        end

        wr(30, 32'h30303030, 4'hf); tick();
        clr_req = 1'b1; tick();
        for (int k = 0; k < 10; k++) begin
            if (k == 0) expect_rd("rclr_busy", 30, 30, 30, 32'h30303030, 32'h30303030, 32'h30303030, 1'b1, 1'b0, M_ALL);
            tick();
        end
        rst = 1'b0;
        expect_rd("rst_midclr", 30, 25, 15, 0, 0, 0, 1'b0, 1'b0, M_ALL);
        tick();
        rst = 1'b1;
        expect_rd("after_rst", 30, 1, 31, 0, 0, 0, 1'b0, 1'b0, M_ALL);
        tick();
        clr_req = 1'b1;
        expect_rd("reclr_start", 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, M_BSY);
        tick();
        for (int k = 0; k <= DEPTH; k++) begin
            expect_rd($sformatf("reclr%0d", k), 0, 0, 0, 0, 0, 0, (k < DEPTH), 1'b0, M_BSY);
            tick();
        end

        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain got %0d entries expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
